expr_pipe_eval: RTL and testbench



---
 rtl/expr_pipe_eval_if.sv | 27 ++
 rtl/expr_pipe_eval.sv | 85 ++++++++
 tb/tb_expr_pipe_eval.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/expr_pipe_eval_if.sv
// Transaction bus for expr_pipe_eval: request handshake, operands, result handshake
// and the live accumulator/count observation outputs.
interface expr_pipe_eval_if #(parameter int W = 6);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            a_signed;
  logic            b_signed;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    y;
  logic            err;
  logic [2*W-1:0]  acc;
  logic [15:0]     count;

  modport master (
    output in_valid, op, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, y, err, acc, count
  );

  modport slave (
    input  in_valid, op, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, y, err, acc, count
  );
endinterface

// File: rtl/expr_pipe_eval.sv
// Pipelined opcode expression evaluator with per-transaction signedness, a persistent
// MAC accumulator and a globally stalled LAT-deep result pipeline.
module expr_pipe_eval #(
  parameter int W   = 6,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  expr_pipe_eval_if.slave bus
);
  localparam int AW = 2 * W;

  typedef struct packed {
    logic [W-1:0] y;
    logic         err;
  } res_t;

  logic           advance, accept, sgn;
  logic [LAT:1]   vld_pipe_q;
  res_t           stage_q [1:LAT];
  res_t           res_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  a_x, b_x, prod;
  logic [15:0]    count_q;
  logic signed [W:0] sh_src, sh_res;

  assign advance = !(vld_pipe_q[LAT] && !bus.out_ready);
  assign accept  = bus.in_valid && advance;

  // Signed only when both operands are; zero-extension otherwise keeps the
  // 2W-bit signed compare and product correct for the unsigned case too.
  assign sgn  = bus.a_signed && bus.b_signed;
  assign a_x  = sgn ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
  assign b_x  = sgn ? {{W{bus.b[W-1]}}, bus.b} : {{W{1'b0}}, bus.b};
  assign prod = a_x * b_x;

  // Shift source carries its own fill bit; b is an unsigned amount.
  assign sh_src = {bus.a_signed & bus.a[W-1], bus.a};
  assign sh_res = sh_src >>> bus.b;

  always_comb begin
    res_d = '0;
    acc_d = acc_q;
    case (bus.op)
      3'd0: res_d.y = bus.a + bus.b;
      3'd1: res_d.y = bus.a - bus.b;
      3'd2: res_d.y = {{(W-1){1'b0}}, ($signed(a_x) < $signed(b_x))};
      3'd3: res_d.y = sh_res[W-1:0];
      3'd4: res_d.y = {{(W-1){1'b0}}, ~^(bus.a ^ bus.b)};
      3'd5: begin
        acc_d   = acc_q + prod;
        res_d.y = acc_d[W-1:0];
      end
      3'd6: acc_d = '0;
      default: res_d.err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      for (int i = 1; i <= LAT; i++) stage_q[i] <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      if (advance) begin
        vld_pipe_q[1] <= accept;
        stage_q[1]    <= accept ? res_d : '0;
        for (int i = LAT; i >= 2; i--) begin
          vld_pipe_q[i] <= vld_pipe_q[i-1];
          stage_q[i]    <= stage_q[i-1];
        end
        if (accept) acc_q <= acc_d;
      end
      if (vld_pipe_q[LAT] && bus.out_ready) count_q <= count_q + 16'd1;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe_q[LAT];
  assign bus.y         = stage_q[LAT].y;
  assign bus.err       = stage_q[LAT].err;
  assign bus.acc       = acc_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_expr_pipe_eval.sv
// Directed bench for expr_pipe_eval: queue-based reference model checked every cycle,
// plus literal expectations on the recorded output stream.
module tb_expr_pipe_eval;
  localparam int W   = 6;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  expr_pipe_eval_if #(.W(W)) bus ();
  expr_pipe_eval #(.W(W), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit err;
    int age;
  } exp_t;

  exp_t        q[$];
  logic [W:0]  log_q[$];
  longint      macc = 0;
  logic [15:0] mcount = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sval(input int v, input bit s);
    return (s && v[W-1]) ? v - (1 << W) : v;
  endfunction

  // Reference semantics from the opcode table, in plain integer arithmetic.
  function automatic void model_op(input int op, input int a, input int b, input bit as,
                                   input bit bs, inout longint acc, output int y, output bit err);
    int     mw = (1 << W) - 1;
    longint am = (longint'(1) << (2 * W)) - 1;
    bit     s  = as && bs;
    int     av = sval(a, s);
    int     bv = sval(b, s);
    y = 0; err = 0;
    case (op)
      0: y = (av + bv) & mw;
      1: y = (av - bv) & mw;
      2: y = (av < bv) ? 1 : 0;
      3: y = (sval(a, as) >>> ((b > 30) ? 30 : b)) & mw;
      4: y = ($countones(a ^ b) % 2 == 0) ? 1 : 0;
      5: begin acc = (acc + longint'(av) * longint'(bv)) & am; y = int'(acc) & mw; end
      6: acc = 0;
      default: err = 1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_ov, hs, adv;
      int y; bit e;
      exp_ov = (q.size() > 0) && (q[0].age >= LAT);
      chk("out_valid", bus.out_valid, exp_ov);
      chk("in_ready", bus.in_ready, !(exp_ov && !bus.out_ready));
      chk("acc", bus.acc, macc);
      chk("count", bus.count, mcount);
      if (exp_ov && bus.out_valid) begin
        chk("y", bus.y, q[0].y);
        chk("err", bus.err, q[0].err);
      end
      if (reset) begin
        q.delete();
        macc = 0;
        mcount = 16'd0;
      end else begin
        hs  = exp_ov && bus.out_ready;
        adv = !(exp_ov && !bus.out_ready);
        if (hs) begin
          log_q.push_back({bus.err, bus.y});
          void'(q.pop_front());
          mcount = mcount + 16'd1;
        end
        if (adv) foreach (q[i]) q[i].age++;
        if (bus.in_valid && adv) begin
          model_op(bus.op, bus.a, bus.b, bus.a_signed, bus.b_signed, macc, y, e);
          q.push_back('{y, e, 1});
        end
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic send(input int op, input int a, input int b, input bit as, input bit bs);
    int guard = 0;
    bus.in_valid = 1'b1; bus.op = 3'(op); bus.a = W'(a); bus.b = W'(b);
    bus.a_signed = as; bus.b_signed = bs;
    #1;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck low, op %0d", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int        ty; bit te; longint tacc;
    logic [W:0] exp_log[15];
    logic [W-1:0] y_hold;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    bus.a_signed = 1'b0; bus.b_signed = 1'b0; bus.out_ready = 1'b1;

    // Pin the model to hand-computed values.
    tacc = 0; model_op(0, 'h3F, 1, 1, 1, tacc, ty, te); chk("pin_add", ty, 0);
    model_op(2, 'h3F, 1, 1, 1, tacc, ty, te); chk("pin_lt_s", ty, 1);
    model_op(2, 'h3F, 1, 1, 0, tacc, ty, te); chk("pin_lt_u", ty, 0);
    model_op(3, 'h20, 2, 1, 0, tacc, ty, te); chk("pin_shr_s", ty, 'h38);
    model_op(3, 'h20, 9, 1, 1, tacc, ty, te); chk("pin_shr_big", ty, 'h3F);
    model_op(5, 'h3D, 5, 1, 1, tacc, ty, te); chk("pin_mac_acc", tacc, 'hFF1);
    chk("pin_mac_y", ty, 'h31);
    model_op(5, 3, 5, 0, 0, tacc, ty, te); chk("pin_mac2_acc", tacc, 0);

    repeat (2) step;
    reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_count", bus.count, 0);
    mon_en = 1'b1;

    // Latency: accepted in cycle 0, visible in cycle 2.
    send(0, 'h3F, 1, 1, 1);
    chk("lat_c1_valid", bus.out_valid, 0);
    step;
    chk("lat_c2_valid", bus.out_valid, 1);
    chk("lat_c2_y", bus.y, 0);
    chk("lat_c2_count", bus.count, 0);
    step;
    chk("lat_c3_count", bus.count, 1);

    send(2, 'h3F, 1, 1, 1); send(2, 'h3F, 1, 1, 0); send(2, 'h3F, 1, 0, 0);
    send(3, 'h20, 2, 1, 0); send(3, 'h20, 2, 0, 0); send(3, 'h20, 9, 1, 1);
    send(6, 0, 0, 0, 0);
    send(5, 'h3D, 5, 1, 1);
    chk("mac1_acc", bus.acc, 'hFF1);
    send(5, 3, 5, 0, 0);
    chk("mac2_acc", bus.acc, 0);
    repeat (4) step;

    // Backpressure: output stalled for several cycles, then released.
    bus.out_ready = 1'b0;
    fork
      begin send(0, 1, 2, 0, 0); send(0, 3, 4, 0, 0); send(0, 5, 6, 0, 0); end
      begin
        repeat (4) step;
        chk("bp_in_ready", bus.in_ready, 0);
        y_hold = bus.y;
        step;
        chk("bp_y_hold", bus.y, y_hold);
        bus.out_ready = 1'b1;
      end
    join
    repeat (5) step;

    send(5, 2, 3, 0, 0);
    send(7, 5, 9, 1, 1);
    repeat (4) step;
    chk("ill_acc_kept", bus.acc, 6);

    exp_log = '{7'h00, 7'h01, 7'h00, 7'h00, 7'h38, 7'h08, 7'h3F, 7'h00, 7'h31, 7'h00,
                7'h03, 7'h07, 7'h0B, 7'h06, 7'h40};
    chk("log_size", log_q.size(), 15);
    for (int i = 0; i < 15 && i < log_q.size(); i++)
      chk($sformatf("log[%0d]", i), log_q[i], exp_log[i]);

    // Reset with two transactions in flight: neither may ever emerge.
    bus.out_ready = 1'b0;
    send(5, 1, 1, 0, 0);
    send(0, 1, 1, 0, 0);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_acc", bus.acc, 0);
    chk("midrst_count", bus.count, 0);
    bus.out_ready = 1'b1;
    repeat (5) step;
    chk("midrst_log_size", log_q.size(), 15);
    chk("midrst_valid_late", bus.out_valid, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
